// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and load/store requesters.
// One transaction in flight; data wins ties unless fetch has waited MAX_WAIT cycles.
module mem_port_arbiter #(
    parameter int unsigned size     = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [size-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [size-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [size-1:0] d_addr,
    input  logic [size-1:0] d_wdata,
    input  logic [2:0]      d_type,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [size-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [size-1:0] mem_addr,
    output logic [size-1:0] mem_wdata,
    output logic [2:0]      mem_type,
    input  logic            mem_ready,
    input  logic [size-1:0] mem_rdata
);

    localparam int unsigned   CntW      = $clog2(MAX_WAIT + 1) > 0 ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CntW-1:0] WaitMax = CntW'(MAX_WAIT);
    // Fetches are always full-word reads.
    localparam logic [2:0]    FetchType = 3'b010;

    typedef enum logic [1:0] {StIdle, StBusyD, StBusyI, StDone} state_e;

    state_e            state_q, state_d;
    logic              fetch_own_q, fetch_own_d;
    logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [size-1:0]   mem_addr_q, mem_addr_d;
    logic [size-1:0]   mem_wdata_q, mem_wdata_d;
    logic [2:0]        mem_type_q, mem_type_d;
    logic              if_gnt_q, if_gnt_d;
    logic              d_gnt_q, d_gnt_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [size-1:0]   if_rdata_q, if_rdata_d;
    logic [size-1:0]   d_rdata_q, d_rdata_d;

    logic fetch_prio;
    logic launch_i;
    logic launch_d;
    logic fetch_busy;

    assign fetch_prio = (wait_cnt_q >= WaitMax);
    assign fetch_busy = (state_q == StBusyI) || ((state_q == StDone) && fetch_own_q);

    always_comb begin
        launch_i = 1'b0;
        launch_d = 1'b0;
        if (state_q == StIdle) begin
            if (fetch_prio && if_req) begin
                launch_i = 1'b1;
            end else if (d_req) begin
                launch_d = 1'b1;
            end else if (if_req) begin
                launch_i = 1'b1;
            end
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!if_req || launch_i) begin
            wait_cnt_d = '0;
        end else if (!fetch_busy && (wait_cnt_q < WaitMax)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_own_d = fetch_own_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_type_d  = mem_type_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (launch_i) begin
                    state_d     = StBusyI;
                    fetch_own_d = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_type_d  = FetchType;
                    if_gnt_d    = 1'b1;
                end else if (launch_d) begin
                    state_d     = StBusyD;
                    fetch_own_d = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_type_d  = d_type;
                    d_gnt_d     = 1'b1;
                end
            end
            StBusyD, StBusyI: begin
                if (mem_ready) begin
                    state_d   = StDone;
                    mem_req_d = 1'b0;
                    if (fetch_own_q) begin
                        if_rdata_d  = mem_rdata;
                        if_rvalid_d = 1'b1;
                    end else begin
                        d_rdata_d  = mem_we_q ? '0 : mem_rdata;
                        d_rvalid_d = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            fetch_own_q <= 1'b0;
            wait_cnt_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_type_q  <= '0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            fetch_own_q <= fetch_own_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_type_q  <= mem_type_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_type  = mem_type_q;
    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a zero-logic memory model returns addr ^ K.
module tb_mem_port_arbiter;

    localparam logic [31:0] K = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_type;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_type;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem_addr ^ K;

    mem_port_arbiter #(.size(32), .MAX_WAIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_type    (d_type),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_type  (mem_type),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; if_req = 1'b1; if_addr = 32'h100; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_type = '0; mem_ready = 1'b1;
        tick(); tick();
        checks++;
        if ({mem_req, mem_we, if_gnt, if_rvalid, d_gnt, d_rvalid} !== 6'b0 || mem_addr !== 0 ||
            mem_wdata !== 0 || mem_type !== 0 || if_rdata !== 0 || d_rdata !== 0) begin
            errors++;
            $display("FAIL reset_outputs: ctl=%b addr=%h wdata=%h type=%h ird=%h drd=%h, want all 0",
                     {mem_req, mem_we, if_gnt, if_rvalid, d_gnt, d_rvalid}, mem_addr, mem_wdata,
                     mem_type, if_rdata, d_rdata);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({mem_req, if_gnt, d_gnt, mem_we, if_rvalid} !== 5'b11000 || mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL fetch_launch: req/ignt/dgnt/we/rv=%b addr=%h, want 11000 addr=00000100",
                     {mem_req, if_gnt, d_gnt, mem_we, if_rvalid}, mem_addr);
        end
        tick();
        checks++;
        if ({if_rvalid, mem_req, if_gnt} !== 3'b100 || if_rdata !== (32'h100 ^ K)) begin
            errors++;
            $display("FAIL fetch_done: rv/req/gnt=%b rdata=%h, want 100 rdata=%h",
                     {if_rvalid, mem_req, if_gnt}, if_rdata, 32'h100 ^ K);
        end
        if_req = 1'b0;
        tick();
        checks++;
        if ({if_rvalid, mem_req, if_gnt} !== 3'b000) begin
            errors++;
            $display("FAIL fetch_idle: rv/req/gnt=%b, want 000", {if_rvalid, mem_req, if_gnt});
        end
    endtask

    task automatic test_priority();
        if_req = 1'b1; if_addr = 32'h104;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_type = 3'b010;
        tick();
        checks++;
        if ({d_gnt, if_gnt, mem_req, mem_we} !== 4'b1011 || mem_addr !== 32'h200 ||
            mem_wdata !== 32'hDEADBEEF || mem_type !== 3'b010) begin
            errors++;
            $display("FAIL data_first: dg/ig/req/we=%b addr=%h wd=%h ty=%b, want 1011 200 DEADBEEF 010",
                     {d_gnt, if_gnt, mem_req, mem_we}, mem_addr, mem_wdata, mem_type);
        end
        tick();
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || if_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL store_done: drv=%b drdata=%h irv=%b, want 1 0 0", d_rvalid, d_rdata,
                     if_rvalid);
        end
        d_req = 1'b0;
        tick();
        tick();
        checks++;
        if ({if_gnt, d_gnt, mem_req, mem_we} !== 4'b1010 || mem_addr !== 32'h104) begin
            errors++;
            $display("FAIL fetch_second: ig/dg/req/we=%b addr=%h, want 1010 104",
                     {if_gnt, d_gnt, mem_req, mem_we}, mem_addr);
        end
        tick();
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== (32'h104 ^ K)) begin
            errors++;
            $display("FAIL fetch_second_done: rv=%b rdata=%h, want 1 %h", if_rvalid, if_rdata,
                     32'h104 ^ K);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        logic [15:0] d_mask;
        logic [15:0] i_mask;
        logic [31:0] load_val;
        logic        got_load;
        d_mask = '0; i_mask = '0; load_val = '0; got_load = 1'b0;
        if_req = 1'b1; if_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_wdata = '0; d_type = 3'b010;
        for (int c = 1; c <= 12; c++) begin
            tick();
            d_mask[c] = d_gnt;
            i_mask[c] = if_gnt;
            if (if_rvalid) if_req = 1'b0;
            if (d_rvalid && !got_load) begin
                load_val = d_rdata;
                got_load = 1'b1;
            end
        end
        d_req = 1'b0;
        checks++;
        if (i_mask !== 16'h0080) begin
            errors++;
            $display("FAIL starve_fetch_gnt: mask=%h, want 0080", i_mask);
        end
        checks++;
        if (d_mask !== 16'h0412) begin
            errors++;
            $display("FAIL starve_data_gnt: mask=%h, want 0412", d_mask);
        end
        checks++;
        if (load_val !== (32'h400 ^ K) || if_rdata !== (32'h300 ^ K)) begin
            errors++;
            $display("FAIL starve_data: load=%h ird=%h, want %h %h", load_val, if_rdata,
                     32'h400 ^ K, 32'h300 ^ K);
        end
        tick();
        checks++;
        if ({if_gnt, d_gnt, mem_req} !== 3'b000) begin
            errors++;
            $display("FAIL starve_quiet: ig/dg/req=%b, want 000", {if_gnt, d_gnt, mem_req});
        end
    endtask

    task automatic test_wait_states();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_type = 3'b000; mem_ready = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h500 || d_rvalid !== 1'b0 ||
                d_gnt !== (c == 1)) begin
                errors++;
                $display("FAIL wait_hold c%0d: req=%b addr=%h rv=%b gnt=%b, want 1 500 0 %b",
                         c, mem_req, mem_addr, d_rvalid, d_gnt, (c == 1));
            end
            if (c == 2) d_req = 1'b0;
            if (c == 4) mem_ready = 1'b1;
        end
        tick();
        checks++;
        if (d_rvalid !== 1'b1 || mem_req !== 1'b0 || d_rdata !== (32'h500 ^ K)) begin
            errors++;
            $display("FAIL wait_done: rv=%b req=%b rdata=%h, want 1 0 %h", d_rvalid, mem_req,
                     d_rdata, 32'h500 ^ K);
        end
        tick();
        checks++;
        if (d_rvalid !== 1'b0 || d_rdata !== (32'h500 ^ K) || if_rdata !== (32'h300 ^ K)) begin
            errors++;
            $display("FAIL rdata_hold: rv=%b drd=%h ird=%h, want 0 %h %h", d_rvalid, d_rdata,
                     if_rdata, 32'h500 ^ K, 32'h300 ^ K);
        end
    endtask

    task automatic test_reset_mid();
        if_req = 1'b1; if_addr = 32'h600;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h700; d_wdata = 32'h12345678; d_type = 3'b001;
        mem_ready = 1'b0;
        tick();
        checks++;
        if (d_gnt !== 1'b1 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL midrst_launch: gnt=%b req=%b, want 1 1", d_gnt, mem_req);
        end
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_ready = 1'b1;
        checks++;
        if ({mem_req, d_rvalid, d_gnt, if_gnt, mem_we} !== 5'b0 || mem_addr !== 0) begin
            errors++;
            $display("FAIL midrst_abandon: req/rv/dg/ig/we=%b addr=%h, want 00000 0",
                     {mem_req, d_rvalid, d_gnt, if_gnt, mem_we}, mem_addr);
        end
        tick();
        checks++;
        if ({d_gnt, if_gnt} !== 2'b10 || mem_addr !== 32'h700 || d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_waitcnt_clear: dg/ig=%b addr=%h rv=%b, want 10 700 0",
                     {d_gnt, if_gnt}, mem_addr, d_rvalid);
        end
        tick();
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL midrst_store_done: rv=%b rdata=%h, want 1 0", d_rvalid, d_rdata);
        end
        d_req = 1'b0;
        tick(); tick();
        checks++;
        if (if_gnt !== 1'b1 || mem_addr !== 32'h600) begin
            errors++;
            $display("FAIL midrst_fetch: gnt=%b addr=%h, want 1 600", if_gnt, mem_addr);
        end
        tick();
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== (32'h600 ^ K)) begin
            errors++;
            $display("FAIL midrst_fetch_done: rv=%b rdata=%h, want 1 %h", if_rvalid, if_rdata,
                     32'h600 ^ K);
        end
        if_req = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_priority();
        test_starvation();
        test_wait_states();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
